cl_mem_responder: RTL and testbench
===================================

# cl_mem_responder

Host-side responder for the 512-bit cache-line interface driven by the CPU cache controller. Accepts line read and write requests on `op_host` / `AddrOut_host` / `DataOut_host`, services them from a local line-addressed array after a programmable latency, and answers with `DataIn_host`, `rd_valid_host` and `tx_done_host`. Stands in for the DMA/host memory controller in system simulation and small FPGA builds.

## Interface
- `LATENCY`, 4: cycles from request acceptance to `tx_done_host`; legal range 1..15.
- `DEPTH`, 256: number of 512-bit lines stored; power of two, 2..4096.
- `clk`  in  1  clock; all logic on rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `op_host`  in  2  request: 2'b00 idle, 2'b01 line read, 2'b10 line write, 2'b11 reserved.
- `AddrOut_host`  in  32  byte address of the line; bits [5:0] ignored.
- `DataOut_host`  in  512  write line data; sampled only at acceptance.
- `DataIn_host`  out  512  read line data.
- `rd_valid_host`  out  1  read data valid; one-cycle pulse.
- `tx_done_host`  out  1  transaction complete; one-cycle pulse for both reads and writes.
- `busy`  out  1  high from acceptance through the `tx_done_host` cycle.

## Operation
- Array: DEPTH x 512 bits. Line index = `AddrOut_host[6 +: log2(DEPTH)]`. Higher address bits alias. Contents are not cleared by reset.
- States:
  - IDLE
    - `op_host` = 01 or 10: accept. Latch op, index and `DataOut_host`. Load the counter with LATENCY-1. Go to WAIT.
    - `op_host` = 00 or 11: stay in IDLE. Reserved ops are dropped silently.
  - WAIT
    - Counter nonzero: decrement.
    - Counter zero: go to DONE.
  - DONE, one cycle:
    - `tx_done_host` = 1.
    - Read: `rd_valid_host` = 1 and `DataIn_host` = array[index].
    - Write: array[index] <= latched data on the edge that ends DONE.
    - Next state is TURN.
  - TURN, one cycle: `op_host` is ignored. This gives the requester a cycle to drop its request. Next state is IDLE.
- `op_host`, address and data changes are ignored from WAIT through TURN; the latched values are used.
- `DataIn_host` is registered. It holds the last read line until the next read completes; writes do not alter it.
- If `op_host` is still nonzero in IDLE after TURN, that is a new request and is accepted.

## Timing
- Reset values: `DataIn_host` = 0, `rd_valid_host` = 0, `tx_done_host` = 0, `busy` = 0, state IDLE, counter 0.
- Request sampled in IDLE at edge N:
  - `busy` is high from cycle N+1.
  - `tx_done_host` (and `rd_valid_host` for reads) is high exactly in cycle N+1+LATENCY.
  - `busy` falls in cycle N+2+LATENCY, which is TURN.
- Back-to-back throughput is one request per LATENCY+3 cycles.
- LATENCY = 1: WAIT lasts one cycle, so DONE is in cycle N+2.
- Read after write to the same line: the read is accepted no earlier than after TURN, so it always returns the newly written data.
- Reset asserted mid-transaction:
  - Outputs clear immediately (asynchronous) and state returns to IDLE.
  - A write not yet at its DONE edge is discarded; the array is never partially written.
  - The first edge after `rst_n` rises may accept a request.

## Configuration
- `CL_MEM_RESP_RANDLAT_EN` not defined: fixed latency of LATENCY cycles per transaction, as above.
- `CL_MEM_RESP_RANDLAT_EN` defined, jittered latency for stress testing:
  - A 16-bit Fibonacci LFSR (taps 16,14,13,11) resets to 16'hACE1 and advances every cycle.
  - At acceptance the counter loads LATENCY-1 + lfsr[2:0], so effective latency is LATENCY..LATENCY+7.
  - The counter is log2(LATENCY+8) bits wide.
  - All handshake rules are otherwise identical.

## Test plan
- Reset then idle:
  - Stimulus: hold `rst_n` low 3 cycles, release, keep `op_host` = 00 for 20 cycles.
  - Required: all outputs stay 0.
- Write then read, LATENCY = 4:
  - Stimulus: write 512'h{16{32'hDEADBEEF}} to 0x0000_1040, then read 0x0000_107F.
  - Required: each `tx_done_host` is 5 cycles after acceptance. The read returns the written line with `rd_valid_host` high for exactly 1 cycle.
- Aliasing and offset, DEPTH = 256:
  - Stimulus: write line A to 0x0000_0000, then read 0x0000_4000.
  - Required: the read returns A.
- Held request and reserved op:
  - Stimulus: keep `op_host` = 01 asserted across TURN.
  - Required: exactly one `tx_done_host` per LATENCY+3 cycles.
  - Stimulus: `op_host` = 11 for 10 cycles.
  - Required: no `busy`, no `tx_done_host`.
- Reset mid-write:
  - Stimulus: write 0xFF..FF to line 5 over old value 0, assert `rst_n` during WAIT, then read line 5.
  - Required: the read returns 0.
- With `CL_MEM_RESP_RANDLAT_EN`, LATENCY = 1:
  - Stimulus: 200 random reads and writes.
  - Required: latency always within 1..8. Data matches a scoreboard model. Never two `tx_done_host` pulses closer than 4 cycles apart.

Source files
------------

// File: rtl/cl_mem_responder.sv
// cl_mem_responder: host-side responder for the 512-bit cache-line interface.
// Accepts a line read or write, waits a programmable latency, then completes
// with a one-cycle tx_done_host pulse (plus rd_valid_host and DataIn_host for reads).
// Optional feature: define CL_MEM_RESP_RANDLAT_EN to add 0..7 cycles of
// LFSR-driven jitter to every transaction's latency.
//
// Handshake: a request is the nonzero op_host level sampled on a rising edge
// while the FSM is IDLE; op/address/data are latched at that edge and ignored
// until the FSM is back in IDLE. Completion is the single cycle where
// tx_done_host is high; busy covers acceptance through that cycle, and the
// following TURN cycle ignores op_host so the requester can drop it.
module cl_mem_responder #(
    parameter int LATENCY = 4,
    parameter int DEPTH   = 256
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [1:0]   op_host,
    input  logic [31:0]  AddrOut_host,
    input  logic [511:0] DataOut_host,
    output logic [511:0] DataIn_host,
    output logic         rd_valid_host,
    output logic         tx_done_host,
    output logic         busy,
    output logic [1:0]   dbg_state
);

    localparam int IW = $clog2(DEPTH);
`ifdef CL_MEM_RESP_RANDLAT_EN
    localparam int CW = $clog2(LATENCY + 8);
`else
    localparam int CW = $clog2(LATENCY + 1);
`endif

    localparam logic [1:0] OP_READ  = 2'b01;
    localparam logic [1:0] OP_WRITE = 2'b10;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WAIT = 2'd1,
        S_DONE = 2'd2,
        S_TURN = 2'd3
    } state_t;

    state_t         state;
    state_t         state_nxt;
    logic [CW-1:0]  cnt;
    logic [CW-1:0]  cnt_nxt;
    logic [CW-1:0]  cnt_load;
    logic           accept;
    logic           is_rd;
    logic [IW-1:0]  idx;
    logic [511:0]   wdata_q;
    logic [511:0]   mem [DEPTH];

`ifdef CL_MEM_RESP_RANDLAT_EN
    logic [15:0]    lfsr;
    logic           unused_randlat;

    // Free-running Fibonacci LFSR (taps 16,14,13,11) supplying latency jitter
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lfsr <= 16'hACE1;
        end else begin
            lfsr <= {lfsr[14:0], lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10]};
        end
    end

    assign cnt_load       = CW'(LATENCY - 1) + CW'(lfsr[2:0]);
    assign unused_randlat = ^lfsr[15:3];
`else
    assign cnt_load = CW'(LATENCY - 1);
`endif

    // Address offset bits and aliasing upper bits never select a line
    logic unused_addr;
    assign unused_addr = ^{AddrOut_host[5:0], AddrOut_host[31:6+IW]};

    // State register and latency counter
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= S_IDLE;
            cnt   <= '0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
        end
    end

    // Next-state logic: IDLE -> WAIT (LATENCY cycles) -> DONE -> TURN -> IDLE
    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        accept    = 1'b0;
        case (state)
            S_IDLE: begin
                if (op_host == OP_READ || op_host == OP_WRITE) begin
                    accept    = 1'b1;
                    cnt_nxt   = cnt_load;
                    state_nxt = S_WAIT;
                end
            end
            S_WAIT: begin
                if (cnt != '0) begin
                    cnt_nxt = cnt - CW'(1);
                end else begin
                    state_nxt = S_DONE;
                end
            end
            S_DONE:  state_nxt = S_TURN;
            default: state_nxt = S_IDLE;
        endcase
    end

    // Request latches: captured once at acceptance, held for the whole transaction
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            is_rd   <= 1'b0;
            idx     <= '0;
            wdata_q <= '0;
        end else if (accept) begin
            is_rd   <= (op_host == OP_READ);
            idx     <= AddrOut_host[6 +: IW];
            wdata_q <= DataOut_host;
        end
    end

    // Read data register: loaded on the edge entering DONE, held until the next read
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            DataIn_host <= '0;
        end else if (state == S_WAIT && cnt == '0 && is_rd) begin
            DataIn_host <= mem[idx];
        end
    end

    // Line array: a write commits only on the edge that ends DONE, so a reset
    // earlier in the transaction leaves the line untouched
    always_ff @(posedge clk) begin
        if (state == S_DONE && !is_rd) begin
            mem[idx] <= wdata_q;
        end
    end

    assign tx_done_host  = (state == S_DONE);
    assign rd_valid_host = (state == S_DONE) && is_rd;
    assign busy          = (state == S_WAIT) || (state == S_DONE);
    assign dbg_state     = state;

endmodule

// File: tb/tb_cl_mem_responder.sv
// Testbench for cl_mem_responder: scenario tasks with inline checks against a
// line-array reference model kept in the bench.
module tb_cl_mem_responder;

`ifdef CL_MEM_RESP_RANDLAT_EN
    localparam int LAT = 1;
`else
    localparam int LAT = 4;
`endif
    localparam int DEPTH = 256;
    localparam logic [1:0] IDLE_CODE = 2'd0;

    // Clock / reset
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc++;

    logic [1:0]   op_host = 2'b00;
    logic [31:0]  AddrOut_host = '0;
    logic [511:0] DataOut_host = '0;
    logic [511:0] DataIn_host;
    logic         rd_valid_host;
    logic         tx_done_host;
    logic         busy;
    logic [1:0]   dbg_state;

    cl_mem_responder #(.LATENCY(LAT), .DEPTH(DEPTH)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .op_host       (op_host),
        .AddrOut_host  (AddrOut_host),
        .DataOut_host  (DataOut_host),
        .DataIn_host   (DataIn_host),
        .rd_valid_host (rd_valid_host),
        .tx_done_host  (tx_done_host),
        .busy          (busy),
        .dbg_state     (dbg_state)
    );

    // Reference model
    logic [511:0] model [DEPTH];
    bit           written [DEPTH];

    int n_pass = 0;
    int n_total = 0;

    typedef struct {
        bit           busy1;
        bit           seen;
        int           k;
        bit           rv;
        bit           busy_done;
        logic [511:0] data;
        bit           turn_quiet;
        logic [511:0] turn_data;
        int           done_cyc;
    } obs_t;

    function automatic int idx_of(input logic [31:0] a);
        return int'((a >> 6) % DEPTH);
    endfunction

    function automatic logic [511:0] rand_line();
        logic [511:0] v;
        for (int i = 0; i < 16; i++) v[i*32 +: 32] = $urandom;
        return v;
    endfunction

    // Measured latency (tx_done cycle minus one) allowed by the build
    function automatic bit lat_ok(input int k);
`ifdef CL_MEM_RESP_RANDLAT_EN
        return (k - 1) >= LAT && (k - 1) <= LAT + 7;
`else
        return (k - 1) == LAT;
`endif
    endfunction

    // Driver/monitor: issue one request from IDLE, observe it, return in IDLE.
    // Inputs are scrambled after acceptance to show the DUT uses latched values.
    task automatic run_txn(input logic [1:0] op, input logic [31:0] addr,
                           input logic [511:0] wd, output obs_t o);
        o = '{default: '0};
        @(negedge clk);
        op_host = op; AddrOut_host = addr; DataOut_host = wd;
        @(posedge clk);
        @(negedge clk);
        op_host = 2'b00; AddrOut_host = $urandom; DataOut_host = rand_line();
        o.busy1 = busy;
        o.k = 1;
        while (!o.seen && o.k <= 40) begin
            if (tx_done_host) begin
                o.seen = 1; o.rv = rd_valid_host; o.busy_done = busy;
                o.data = DataIn_host; o.done_cyc = cyc;
            end else begin
                @(negedge clk);
                o.k++;
            end
        end
        @(negedge clk);
        o.turn_quiet = !tx_done_host && !rd_valid_host && !busy;
        o.turn_data = DataIn_host;
        @(negedge clk);
        if (op == 2'b10 && o.seen) begin
            model[idx_of(addr)] = wd;
            written[idx_of(addr)] = 1;
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0; op_host = 2'b00;
        repeat (3) begin
            @(negedge clk);
            n_total++;
            if ({DataIn_host, rd_valid_host, tx_done_host, busy} !== '0)
                $display("FAIL reset_hold: busy=%0b tx=%0b rv=%0b data_nonzero=%0b required all 0",
                         busy, tx_done_host, rd_valid_host, |DataIn_host);
            else n_pass++;
        end
        rst_n = 1'b1;
        n_total++;
        if (dbg_state !== IDLE_CODE) $display("FAIL reset_state: got %0d required %0d", dbg_state, IDLE_CODE);
        else n_pass++;
        repeat (20) begin
            @(negedge clk);
            n_total++;
            if ({DataIn_host, rd_valid_host, tx_done_host, busy} !== '0)
                $display("FAIL reset_idle: busy=%0b tx=%0b rv=%0b data_nonzero=%0b required all 0",
                         busy, tx_done_host, rd_valid_host, |DataIn_host);
            else n_pass++;
        end
    endtask

    task automatic test_write_read();
        obs_t o;
        logic [511:0] line = {16{32'hDEADBEEF}};
        run_txn(2'b10, 32'h0000_1040, line, o);
        n_total++;
        if (!o.seen || !lat_ok(o.k)) $display("FAIL wr_latency: done at %0d cycles (seen=%0b) required %0d", o.k, o.seen, LAT + 1);
        else n_pass++;
        n_total++;
        if (o.busy1 !== 1'b1 || o.busy_done !== 1'b1) $display("FAIL wr_busy: accept=%0b done=%0b required 1/1", o.busy1, o.busy_done);
        else n_pass++;
        n_total++;
        if (o.rv !== 1'b0) $display("FAIL wr_no_rd_valid: got %0b required 0", o.rv);
        else n_pass++;
        n_total++;
        if (!o.turn_quiet) $display("FAIL wr_turn_quiet: got 0 required 1");
        else n_pass++;

        run_txn(2'b01, 32'h0000_107F, '0, o);
        n_total++;
        if (!o.seen || !lat_ok(o.k)) $display("FAIL rd_latency: done at %0d cycles (seen=%0b) required %0d", o.k, o.seen, LAT + 1);
        else n_pass++;
        n_total++;
        if (o.rv !== 1'b1) $display("FAIL rd_valid: got %0b required 1", o.rv);
        else n_pass++;
        n_total++;
        if (o.data !== line) $display("FAIL rd_data: got %h required %h", o.data, line);
        else n_pass++;
        n_total++;
        if (!o.turn_quiet) $display("FAIL rd_valid_one_cycle: pulse longer than 1 cycle");
        else n_pass++;
        n_total++;
        if (o.turn_data !== line) $display("FAIL rd_data_hold: got %h required %h", o.turn_data, line);
        else n_pass++;
    endtask

    task automatic test_alias();
        obs_t o;
        logic [511:0] a = rand_line();
        run_txn(2'b10, 32'h0000_0000, a, o);
        run_txn(2'b01, 32'h0000_4000, '0, o);
        n_total++;
        if (!o.seen || o.rv !== 1'b1 || o.data !== a)
            $display("FAIL alias_read: seen=%0b rv=%0b got %h required %h", o.seen, o.rv, o.data, a);
        else n_pass++;
    endtask

    task automatic test_held();
        int times[$];
`ifdef CL_MEM_RESP_RANDLAT_EN
        int win = 3 * (LAT + 10);
`else
        int win = 3 * (LAT + 3);
`endif
        @(negedge clk);
        op_host = 2'b01; AddrOut_host = 32'h0000_1040;
        for (int i = 1; i <= win; i++) begin
            @(negedge clk);
            if (tx_done_host) times.push_back(cyc);
        end
        op_host = 2'b00;
`ifdef CL_MEM_RESP_RANDLAT_EN
        n_total++;
        if (times.size() < 3) $display("FAIL held_count: got %0d required >= 3", times.size());
        else n_pass++;
        for (int i = 1; i < times.size(); i++) begin
            n_total++;
            if (times[i] - times[i-1] < LAT + 3 || times[i] - times[i-1] > LAT + 10)
                $display("FAIL held_gap: got %0d required %0d..%0d", times[i] - times[i-1], LAT + 3, LAT + 10);
            else n_pass++;
        end
`else
        n_total++;
        if (times.size() != 3) $display("FAIL held_count: got %0d required 3", times.size());
        else n_pass++;
        for (int i = 1; i < times.size(); i++) begin
            n_total++;
            if (times[i] - times[i-1] != LAT + 3)
                $display("FAIL held_gap: got %0d required %0d", times[i] - times[i-1], LAT + 3);
            else n_pass++;
        end
`endif
        repeat (2 * (LAT + 12)) @(negedge clk);
    endtask

    task automatic test_reserved();
        @(negedge clk);
        op_host = 2'b11; AddrOut_host = $urandom;
        repeat (10) begin
            @(negedge clk);
            n_total++;
            if (busy !== 1'b0 || tx_done_host !== 1'b0)
                $display("FAIL reserved_op: busy=%0b tx=%0b required 0/0", busy, tx_done_host);
            else n_pass++;
        end
        op_host = 2'b00;
    endtask

    task automatic test_reset_mid_write();
        obs_t o;
        run_txn(2'b10, 32'h0000_0140, '0, o);
        @(negedge clk);
        op_host = 2'b10; AddrOut_host = 32'h0000_0140; DataOut_host = '1;
        @(posedge clk);
        @(negedge clk);
        op_host = 2'b00;
        n_total++;
        if (busy !== 1'b1) $display("FAIL midrst_busy: got %0b required 1", busy);
        else n_pass++;
        rst_n = 1'b0;
        #1;
        n_total++;
        if ({DataIn_host, rd_valid_host, tx_done_host, busy} !== '0 || dbg_state !== IDLE_CODE)
            $display("FAIL midrst_async_clear: busy=%0b tx=%0b data_nonzero=%0b state=%0d required 0",
                     busy, tx_done_host, |DataIn_host, dbg_state);
        else n_pass++;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        run_txn(2'b01, 32'h0000_0140, '0, o);
        n_total++;
        if (!o.seen || o.data !== model[5])
            $display("FAIL midrst_read: seen=%0b got %h required %h", o.seen, o.data, model[5]);
        else n_pass++;
    endtask

    task automatic test_random();
        obs_t o;
        int prev_done = -1;
        for (int t = 0; t < 200; t++) begin
            logic [1:0]   op = ($urandom_range(0, 1) == 1) ? 2'b10 : 2'b01;
            int           line = $urandom_range(0, 15);
            logic [31:0]  addr = ($urandom & 32'hFFFF_C000) | (32'(line) << 6) | 32'($urandom_range(0, 63));
            logic [511:0] wd = rand_line();
            logic [511:0] exp = model[idx_of(addr)];
            bit           known = written[idx_of(addr)];
            run_txn(op, addr, wd, o);
            n_total++;
            if (!o.seen || !lat_ok(o.k))
                $display("FAIL rand_latency: txn %0d done at %0d (seen=%0b) required latency %0d..%0d", t, o.k, o.seen, LAT, LAT + 7);
            else n_pass++;
            if (op == 2'b01 && known) begin
                n_total++;
                if (o.rv !== 1'b1 || o.data !== exp)
                    $display("FAIL rand_read: txn %0d rv=%0b got %h required %h", t, o.rv, o.data, exp);
                else n_pass++;
            end
            if (prev_done >= 0) begin
                n_total++;
                if (o.done_cyc - prev_done < LAT + 3)
                    $display("FAIL rand_done_gap: txn %0d got %0d required >= %0d", t, o.done_cyc - prev_done, LAT + 3);
                else n_pass++;
            end
            prev_done = o.done_cyc;
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int i = 0; i < DEPTH; i++) written[i] = 0;
        test_reset();
        test_write_read();
        test_alias();
        test_held();
        test_reserved();
        test_reset_mid_write();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
